// File: rtl/tod_pkg.sv
// Shared timekeeping definitions: field widths, limits, packed-word
// layout and the wrap-around field increment.
package tod_pkg;

  localparam int TF_W = 6;
  localparam int TIME_W = 3 * TF_W;

  localparam logic [TF_W-1:0] SEC_MAX = 6'd59;
  localparam logic [TF_W-1:0] MIN_MAX = 6'd59;
  localparam logic [TF_W-1:0] HOUR_MAX = 6'd23;

  localparam int SEC_LSB = 0;
  localparam int MIN_LSB = 6;
  localparam int HOUR_LSB = 12;

  typedef enum logic {
    MODE_RUN = 1'b0,
    MODE_SET = 1'b1
  } mode_e;

  typedef struct packed {
    logic [TF_W-1:0] hour;
    logic [TF_W-1:0] min;
    logic [TF_W-1:0] sec;
  } tod_t;

  // Anything at or past the last legal value folds back to zero.
  function automatic logic [TF_W-1:0] fld_inc(
    input logic [TF_W-1:0] v,
    input logic [TF_W-1:0] max
  );
    return (v >= max) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchroniser for an asynchronous level input, plus a
// one-cycle pulse on each synchronised rising edge.
module key_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_sync,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_sync = r_s2;
  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/tod_counter.sv
// Time-of-day counter: 1 s prescaler, 60/60/24 fields, set mode
// with per-field step keys, tick / midnight / 1 Hz outputs.
import tod_pkg::*;

module tod_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_mode,
  input  logic              sec_key,
  input  logic              min_key,
  input  logic              hour_key,
  output logic [TIME_W-1:0] time_o,
  output logic              tick_o,
  output logic              rollover_o,
  output logic              clk_1hz_o
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);

  logic [PW-1:0] r_presc;
  tod_t          r_time;

  logic  w_mode_sync;
  logic  w_mode_rise_unused;
  logic  w_sec_sync_unused;
  logic  w_min_sync_unused;
  logic  w_hour_sync_unused;
  logic  w_sec_rise;
  logic  w_min_rise;
  logic  w_hour_rise;
  mode_e w_mode;
  logic  w_run;
  logic  w_tick;
  logic  w_midnight;

  key_edge_sync u_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (set_mode),
    .o_sync(w_mode_sync),
    .o_rise(w_mode_rise_unused)
  );

  key_edge_sync u_sec (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (sec_key),
    .o_sync(w_sec_sync_unused),
    .o_rise(w_sec_rise)
  );

  key_edge_sync u_min (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (min_key),
    .o_sync(w_min_sync_unused),
    .o_rise(w_min_rise)
  );

  key_edge_sync u_hour (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (hour_key),
    .o_sync(w_hour_sync_unused),
    .o_rise(w_hour_rise)
  );

  // The second synchroniser flop is the mode state register.
  assign w_mode = mode_e'(w_mode_sync);
  assign w_run = (w_mode == MODE_RUN);
  assign w_tick = w_run && (r_presc == P_LAST);

  assign w_midnight = (r_time.hour == HOUR_MAX) &&
                      (r_time.min == MIN_MAX) &&
                      (r_time.sec == SEC_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_time  <= '0;
    end else begin
      unique case (w_mode)
        MODE_RUN: begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (w_tick) begin
            r_time.sec <= fld_inc(r_time.sec, SEC_MAX);
            if (r_time.sec >= SEC_MAX) begin
              r_time.min <= fld_inc(r_time.min, MIN_MAX);
              if (r_time.min >= MIN_MAX)
                r_time.hour <= fld_inc(r_time.hour, HOUR_MAX);
            end
          end
        end
        MODE_SET: begin
          r_presc <= '0;
          if (w_sec_rise)
            r_time.sec <= fld_inc(r_time.sec, SEC_MAX);
          if (w_min_rise)
            r_time.min <= fld_inc(r_time.min, MIN_MAX);
          if (w_hour_rise)
            r_time.hour <= fld_inc(r_time.hour, HOUR_MAX);
        end
      endcase
    end
  end

  assign time_o = r_time;
  assign tick_o = w_tick;
  assign rollover_o = w_tick && w_midnight;
  assign clk_1hz_o = w_run && (r_presc >= P_HALF);

endmodule
